// File: rtl/pipelined_floating_point_multiplier.sv
// Three-stage IEEE-754-style multiplier with valid/ready on both sides and per-result exception flags.
// Define FP_MUL_STICKY_FLAGS_EN to add the flags_clear input and the sticky_flags accumulator output.
module pipelined_floating_point_multiplier #(
  parameter int EXPONENT_WIDTH   = 8,
  parameter int MANTISSA_WIDTH   = 23,
  parameter int ROUND_TO_NEAREST = 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] a,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] b,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] out,
  output logic                                   underflow_flag,
  output logic                                   overflow_flag,
  output logic                                   invalid_operation_flag
`ifdef FP_MUL_STICKY_FLAGS_EN
  ,
  input  logic                                   flags_clear,
  output logic [2:0]                             sticky_flags
`endif
);
  localparam int E  = EXPONENT_WIDTH;
  localparam int M  = MANTISSA_WIDTH;
  localparam int W  = E + M + 1;
  localparam int P  = 2 * (M + 1);
  localparam int XW = E + 2;
  localparam logic [XW-1:0] BIAS_X  = XW'((1 << (E - 1)) - 1);
  localparam logic [XW-2:0] EXP_MAX = {1'b0, {E{1'b1}}};
  localparam logic [M-1:0]  QNAN_M  = (E == 4 && M == 3) ? {M{1'b1}} : (M'(1) << (M - 1));

  typedef enum logic [1:0] {SPC_NONE, SPC_NAN, SPC_INF, SPC_ZERO} spc_e;

  logic stall, adv;
  assign stall    = out_valid_q & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = ~stall;

  // Stage 1: unpack and classify
  logic            v1_d, v1_q, sign1_d, sign1_q;
  logic [XW-1:0]   exp1_d, exp1_q;
  logic [M:0]      ma1_d, ma1_q, mb1_d, mb1_q;
  logic            az1_d, az1_q, ai1_d, ai1_q, asn1_d, asn1_q, aqn1_d, aqn1_q;
  logic            bz1_d, bz1_q, bi1_d, bi1_q, bsn1_d, bsn1_q, bqn1_d, bqn1_q;
  logic [E-1:0]    a_e, b_e;
  logic            a_nan, b_nan;

  always_comb begin
    a_e     = a[E+M-1:M];
    b_e     = b[E+M-1:M];
    a_nan   = (&a_e) & (|a[M-1:0]);
    b_nan   = (&b_e) & (|b[M-1:0]);
    v1_d    = in_valid;
    sign1_d = a[W-1] ^ b[W-1];
    exp1_d  = {2'b00, a_e} + {2'b00, b_e} - BIAS_X;
    ma1_d   = {1'b1, a[M-1:0]};
    mb1_d   = {1'b1, b[M-1:0]};
    az1_d   = (a_e == '0);
    bz1_d   = (b_e == '0);
    ai1_d   = (&a_e) & ~(|a[M-1:0]);
    bi1_d   = (&b_e) & ~(|b[M-1:0]);
    asn1_d  = a_nan & ~a[M-1];
    aqn1_d  = a_nan & a[M-1];
    bsn1_d  = b_nan & ~b[M-1];
    bqn1_d  = b_nan & b[M-1];
  end

  // Stage 2: mantissa product and special-case decision
  logic            v2_d, v2_q, sign2_d, sign2_q, inv2_d, inv2_q;
  logic [XW-1:0]   exp2_d, exp2_q;
  logic [P-1:0]    prod2_d, prod2_q;
  spc_e            spc2_d, spc2_q;

  always_comb begin
    v2_d    = v1_q;
    sign2_d = sign1_q;
    exp2_d  = exp1_q;
    prod2_d = P'(ma1_q) * P'(mb1_q);
    inv2_d  = 1'b0;
    spc2_d  = SPC_NONE;
    if (asn1_q | aqn1_q | bsn1_q | bqn1_q) begin
      spc2_d = SPC_NAN;
      inv2_d = asn1_q | bsn1_q | (aqn1_q ^ bqn1_q);
    end else if ((az1_q & bi1_q) | (ai1_q & bz1_q)) begin
      spc2_d = SPC_NAN;
      inv2_d = 1'b1;
    end else if (ai1_q | bi1_q) begin
      spc2_d = SPC_INF;
    end else if (az1_q | bz1_q) begin
      spc2_d = SPC_ZERO;
    end
  end

  // Stage 3: normalise, round, pack
  logic            out_valid_d, out_valid_q, uf3_d, uf3_q, of3_d, of3_q, inv3_d, inv3_q;
  logic [W-1:0]    out_d, out_q;
  logic            msb, guard, sticky, round_up, carry;
  logic [M-1:0]    frac;
  logic [M:0]      frac_rnd;
  logic [XW-1:0]   exp_n, exp_f;

  always_comb begin
    msb      = prod2_q[P-1];
    frac     = msb ? prod2_q[P-2 -: M] : prod2_q[P-3 -: M];
    guard    = msb ? prod2_q[M] : prod2_q[M-1];
    sticky   = msb ? (|prod2_q[M-1:0]) : (|prod2_q[M-2:0]);
    round_up = (ROUND_TO_NEAREST != 0) && guard && (sticky || frac[0]);
    frac_rnd = {1'b0, frac} + {{M{1'b0}}, round_up};
    carry    = frac_rnd[M];
    exp_n    = exp2_q + {{(XW-1){1'b0}}, msb};
    exp_f    = exp_n + {{(XW-1){1'b0}}, carry};
    out_valid_d = v2_q;
    out_d    = '0;
    uf3_d    = 1'b0;
    of3_d    = 1'b0;
    inv3_d   = 1'b0;
    if (v2_q) begin
      case (spc2_q)
        SPC_NAN: begin
          out_d  = {1'b1, {E{1'b1}}, QNAN_M};
          inv3_d = inv2_q;
        end
        SPC_INF:  out_d = {sign2_q, {E{1'b1}}, {M{1'b0}}};
        SPC_ZERO: out_d = {sign2_q, {(W-1){1'b0}}};
        default: begin
          if (exp_n[XW-1] || exp_n == '0) begin
            out_d = {sign2_q, {(W-1){1'b0}}};
            uf3_d = 1'b1;
          end else if (!exp_f[XW-1] && exp_f[XW-2:0] >= EXP_MAX) begin
            out_d = {sign2_q, {E{1'b1}}, {M{1'b0}}};
            of3_d = 1'b1;
          end else begin
            out_d = {sign2_q, exp_f[E-1:0], frac_rnd[M-1:0]};
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0; sign1_q <= 1'b0; exp1_q <= '0; ma1_q <= '0; mb1_q <= '0;
      az1_q <= 1'b0; ai1_q <= 1'b0; asn1_q <= 1'b0; aqn1_q <= 1'b0;
      bz1_q <= 1'b0; bi1_q <= 1'b0; bsn1_q <= 1'b0; bqn1_q <= 1'b0;
      v2_q <= 1'b0; sign2_q <= 1'b0; inv2_q <= 1'b0; exp2_q <= '0; prod2_q <= '0; spc2_q <= SPC_NONE;
      out_valid_q <= 1'b0; out_q <= '0; uf3_q <= 1'b0; of3_q <= 1'b0; inv3_q <= 1'b0;
    end else if (adv) begin
      v1_q <= v1_d; sign1_q <= sign1_d; exp1_q <= exp1_d; ma1_q <= ma1_d; mb1_q <= mb1_d;
      az1_q <= az1_d; ai1_q <= ai1_d; asn1_q <= asn1_d; aqn1_q <= aqn1_d;
      bz1_q <= bz1_d; bi1_q <= bi1_d; bsn1_q <= bsn1_d; bqn1_q <= bqn1_d;
      v2_q <= v2_d; sign2_q <= sign2_d; inv2_q <= inv2_d; exp2_q <= exp2_d; prod2_q <= prod2_d; spc2_q <= spc2_d;
      out_valid_q <= out_valid_d; out_q <= out_d; uf3_q <= uf3_d; of3_q <= of3_d; inv3_q <= inv3_d;
    end
  end

  assign out_valid              = out_valid_q;
  assign out                    = out_q;
  assign underflow_flag         = uf3_q;
  assign overflow_flag          = of3_q;
  assign invalid_operation_flag = inv3_q;

`ifdef FP_MUL_STICKY_FLAGS_EN
  // A flag arriving in the same cycle as a clear survives the clear
  logic [2:0] sticky_d, sticky_q;

  always_comb begin
    sticky_d = flags_clear ? 3'b000 : sticky_q;
    if (out_valid_q && out_ready)
      sticky_d = sticky_d | {inv3_q, of3_q, uf3_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= 3'b000;
    else        sticky_q <= sticky_d;
  end

  assign sticky_flags = sticky_q;
`endif
endmodule

// File: tb/tb_pipelined_floating_point_multiplier.sv
// Scoreboard bench for the FP32 multiplier: runs a round-to-nearest and a truncating instance side by side.
module tb_pipelined_floating_point_multiplier;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready;
  logic [31:0] a_in, b_in;
  logic        in_ready, out_valid, uf, of, inv;
  logic [31:0] out;
  logic        in_ready_tr, out_valid_tr, uf_tr, of_tr, inv_tr;
  logic [31:0] out_tr;
`ifdef FP_MUL_STICKY_FLAGS_EN
  logic        flags_clear;
  logic [2:0]  sticky_flags, sticky_flags_tr;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipelined_floating_point_multiplier dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a_in), .b(b_in),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .underflow_flag(uf), .overflow_flag(of), .invalid_operation_flag(inv)
`ifdef FP_MUL_STICKY_FLAGS_EN
    , .flags_clear(flags_clear), .sticky_flags(sticky_flags)
`endif
  );

  pipelined_floating_point_multiplier #(.ROUND_TO_NEAREST(0)) dut_tr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_tr), .a(a_in), .b(b_in),
    .out_valid(out_valid_tr), .out_ready(out_ready), .out(out_tr),
    .underflow_flag(uf_tr), .overflow_flag(of_tr), .invalid_operation_flag(inv_tr)
`ifdef FP_MUL_STICKY_FLAGS_EN
    , .flags_clear(flags_clear), .sticky_flags(sticky_flags_tr)
`endif
  );

  // Flags are {invalid, overflow, underflow}; rne/tr are the round-to-nearest and truncating answers
  typedef struct {
    logic [31:0] a, b, rne;
    logic [2:0]  rf;
    logic [31:0] tr;
    logic [2:0]  tf;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] rne;
    logic [2:0]  rf;
    logic [31:0] tr;
    logic [2:0]  tf;
  } exp_t;

  vec_t vt [16] = '{
    '{32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, 32'h40400000, 3'b000},
    '{32'h7F800000, 32'h00000000, 32'hFFC00000, 3'b100, 32'hFFC00000, 3'b100},
    '{32'h7FA00000, 32'h3F800000, 32'hFFC00000, 3'b100, 32'hFFC00000, 3'b100},
    '{32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010, 32'h7F800000, 3'b010},
    '{32'h80800000, 32'h00800000, 32'h80000000, 3'b001, 32'h80000000, 3'b001},
    '{32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000, 32'h3F800002, 3'b000},
    '{32'h3FC00001, 32'h3FC00001, 32'h40100002, 3'b000, 32'h40100001, 3'b000},
    '{32'h3FC00000, 32'h3F800001, 32'h3FC00002, 3'b000, 32'h3FC00001, 3'b000},
    '{32'h3FC00000, 32'h3F800003, 32'h3FC00004, 3'b000, 32'h3FC00004, 3'b000},
    '{32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 3'b000, 32'h3FFFFFFF, 3'b000},
    '{32'h7F7FFFFE, 32'h3F800001, 32'h7F800000, 3'b010, 32'h7F7FFFFF, 3'b000},
    '{32'h7FC00000, 32'h7FC00000, 32'hFFC00000, 3'b000, 32'hFFC00000, 3'b000},
    '{32'h7FC00000, 32'h3F800000, 32'hFFC00000, 3'b100, 32'hFFC00000, 3'b100},
    '{32'hFF800000, 32'h3F800000, 32'hFF800000, 3'b000, 32'hFF800000, 3'b000},
    '{32'h80000000, 32'h40400000, 32'h80000000, 3'b000, 32'h80000000, 3'b000},
    '{32'h00400000, 32'h3F800000, 32'h00000000, 3'b000, 32'h00000000, 3'b000}
  };

  exp_t sb [$];
  exp_t mon_e;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Offers one operand pair and records its expected results once the DUT is ready to take it
  task automatic applyStimulus(input int i);
    int waitCycles = 0;
    in_valid = 1'b1;
    a_in     = vt[i].a;
    b_in     = vt[i].b;
    @(negedge clk);
    while (!in_ready && waitCycles < 100) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) checkOutput("accept_timeout", 64'd0, 64'd1);
    else sb.push_back('{i, vt[i].rne, vt[i].rf, vt[i].tr, vt[i].tf});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    checkOutput(name, 64'(sb.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      checkOutput("tr_valid_align", 64'(out_valid_tr), 64'(out_valid));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_result", 64'(out), 64'hDEAD_0000_0000);
        end else begin
          mon_e = sb.pop_front();
          checkOutput($sformatf("v%0d_rne_out", mon_e.idx), 64'(out), 64'(mon_e.rne));
          checkOutput($sformatf("v%0d_rne_flags", mon_e.idx), 64'({inv, of, uf}), 64'(mon_e.rf));
          checkOutput($sformatf("v%0d_tr_out", mon_e.idx), 64'(out_tr), 64'(mon_e.tr));
          checkOutput($sformatf("v%0d_tr_flags", mon_e.idx), 64'({inv_tr, of_tr, uf_tr}), 64'(mon_e.tf));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_in      = '0;
    b_in      = '0;
`ifdef FP_MUL_STICKY_FLAGS_EN
    flags_clear = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out", 64'(out), 64'd0);
    checkOutput("reset_flags", 64'({inv, of, uf}), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
`ifdef FP_MUL_STICKY_FLAGS_EN
    checkOutput("reset_sticky", 64'(sticky_flags), 64'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] latency check");
    applyStimulus(0);
    @(negedge clk); checkOutput("latency_c1", 64'(out_valid), 64'd0);
    @(negedge clk); checkOutput("latency_c2", 64'(out_valid), 64'd0);
    @(negedge clk); checkOutput("latency_c3", 64'(out_valid), 64'd1);
    waitDrain("drain_latency");

    $display("[TB] stream of 8 with out_ready low in cycles 4-5");
    fork
      begin
        for (int i = 1; i <= 8; i++) applyStimulus(i);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk); checkOutput("stall_in_ready_c4", 64'(in_ready), 64'd0);
        @(posedge clk);
        @(negedge clk); checkOutput("stall_in_ready_c5", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    waitDrain("drain_stream");

    $display("[TB] remaining directed vectors");
    for (int i = 9; i < 16; i++) applyStimulus(i);
    waitDrain("drain_rest");

    $display("[TB] reset with operations in flight");
    applyStimulus(0);
    applyStimulus(5);
    applyStimulus(6);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midreset_out", 64'(out), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("post_reset_idle", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    applyStimulus(10);
    waitDrain("drain_after_reset");

`ifdef FP_MUL_STICKY_FLAGS_EN
    $display("[TB] sticky flags");
    applyStimulus(3);
    waitDrain("drain_sticky_ovf");
    checkOutput("sticky_ovf", 64'(sticky_flags), 64'b010);
    applyStimulus(1);
    begin
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
      checkOutput("sticky_wait_valid", 64'(out_valid), 64'd1);
    end
    flags_clear = 1'b1;
    @(posedge clk);
    #1 flags_clear = 1'b0;
    checkOutput("sticky_race", 64'(sticky_flags), 64'b100);
    flags_clear = 1'b1;
    @(posedge clk);
    #1 flags_clear = 1'b0;
    checkOutput("sticky_cleared", 64'(sticky_flags), 64'd0);
    waitDrain("drain_sticky");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
